oam_dma_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/oam_dma_arbiter.sv | 170 +++++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the CPU bus fabric (OAM DMA arbiter).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaStarting,
        DmaActive
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]  OAM_DMA_LEN  = 8'd160;
    localparam logic [7:0]  HI_PAGE      = 8'hFF;

    // Sources at or above 0xE0 hit echo RAM, which mirrors work RAM 0x20 pages lower.
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

    function automatic logic [7:0] dma_eff_src(input logic [7:0] src);
        return (src >= ECHO_BASE) ? (src - ECHO_OFFSET) : src;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Purpose: owns the CPU system-bus port; holds the 0xFF46 DMA source register and copies
//          160 bytes from {src,8'h00} into OAM, one byte per M-cycle, locking the CPU out meanwhile.
// Latency: CPU routing is combinational (zero added latency); DMA starts one M-cycle after the write.
// Backpressure: none; locked-out CPU reads below 0xFF00 return 0xFF and writes are dropped.
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   t_cycle               CPU T-cycle phase; 3 is the commit edge of the M-cycle
//   cpu_*                 CPU-side bus (addr/enable/write/wdata in, rdata out)
//   bus_*                 external bus 0x0000-0xFEFF (DMA reads are driven here while active)
//   hi_*                  high page 0xFF00-0xFFFF except 0xFF46
//   oam_*                 OAM write port, strobe valid during t_cycle==3 of active M-cycles
//   dma_active            registered, high while the CPU is locked out of bus_*
import cpu_pkg::*;

module oam_dma_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  hi_addr,
    output logic        hi_enable,
    output logic        hi_write,
    output logic [7:0]  hi_wdata,
    input  logic [7:0]  hi_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = OAM_DMA_LEN - 8'd1;

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q, src_d;          // architectural 0xFF46 value
    logic [7:0] cur_src_q, cur_src_d;  // source of the transfer currently running
    logic       pending_q, pending_d;
    logic       dma_active_q, dma_active_d;

    logic       commit;
    logic       is_hi;
    logic       is_dma_reg;
    logic       dma_reg_wr;

    assign commit     = (t_cycle == 2'd3);
    assign is_hi      = (cpu_addr[15:8] == HI_PAGE);
    assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
    assign dma_reg_wr = cpu_enable && cpu_write && is_dma_reg && commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DmaIdle;
            idx_q        <= 8'd0;
            src_q        <= 8'hFF;
            cur_src_q    <= 8'hFF;
            pending_q    <= 1'b0;
            dma_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            src_q        <= src_d;
            cur_src_q    <= cur_src_d;
            pending_q    <= pending_d;
            dma_active_q <= dma_active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        src_d     = src_q;
        cur_src_d = cur_src_q;
        pending_d = pending_q;

        if (dma_reg_wr) begin
            src_d = cpu_wdata;
        end

        if (commit) begin
            case (state_q)
                DmaIdle: begin
                    if (dma_reg_wr) begin
                        state_d = DmaStarting;
                    end
                end
                DmaStarting: begin
                    // A second write here just reloads src; Starting is re-entered.
                    if (!dma_reg_wr) begin
                        state_d   = DmaActive;
                        idx_d     = 8'd0;
                        cur_src_d = src_q;
                    end
                end
                DmaActive: begin
                    if (pending_q) begin
                        // Restart: the continuation byte is done, begin again from the latest src.
                        idx_d     = 8'd0;
                        cur_src_d = src_d;
                        pending_d = 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        if (dma_reg_wr) begin
                            // Nothing left to continue; restart straight away without dropping the lock.
                            idx_d     = 8'd0;
                            cur_src_d = src_d;
                        end else begin
                            state_d = DmaIdle;
                            idx_d   = 8'd0;
                        end
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        pending_d = dma_reg_wr;
                    end
                end
                default: begin
                    state_d = DmaIdle;
                    idx_d   = 8'd0;
                end
            endcase
        end

        dma_active_d = (state_d == DmaActive);
    end

    // Routing: combinational from registered state, cpu_addr and t_cycle.
    always_comb begin
        hi_addr   = cpu_addr[7:0];
        hi_wdata  = cpu_wdata;
        hi_enable = cpu_enable && is_hi && !is_dma_reg;
        hi_write  = cpu_enable && cpu_write && is_hi && !is_dma_reg;

        if (dma_active_q) begin
            bus_addr   = {dma_eff_src(cur_src_q), idx_q};
            bus_enable = 1'b1;
            bus_write  = 1'b0;
            bus_wdata  = 8'h00;
        end else begin
            bus_addr   = cpu_addr;
            bus_enable = cpu_enable && !is_hi;
            bus_write  = cpu_enable && cpu_write && !is_hi;
            bus_wdata  = cpu_wdata;
        end

        if (is_dma_reg) begin
            cpu_rdata = src_q;
        end else if (is_hi) begin
            cpu_rdata = hi_rdata;
        end else if (dma_active_q) begin
            cpu_rdata = 8'hFF;
        end else begin
            cpu_rdata = bus_rdata;
        end

        oam_write = dma_active_q && commit;
        oam_addr  = oam_write ? idx_q : 8'd0;
        oam_wdata = oam_write ? bus_rdata : 8'd0;
    end

    assign dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  t_cycle;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  hi_addr;
    logic        hi_enable;
    logic        hi_write;
    logic [7:0]  hi_wdata;
    logic [7:0]  hi_rdata;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    oam_dma_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .t_cycle    (t_cycle),
        .cpu_addr   (cpu_addr),
        .cpu_enable (cpu_enable),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .bus_addr   (bus_addr),
        .bus_enable (bus_enable),
        .bus_write  (bus_write),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .hi_addr    (hi_addr),
        .hi_enable  (hi_enable),
        .hi_write   (hi_write),
        .hi_wdata   (hi_wdata),
        .hi_rdata   (hi_rdata),
        .oam_addr   (oam_addr),
        .oam_write  (oam_write),
        .oam_wdata  (oam_wdata),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) t_cycle <= 2'd0;
        else       t_cycle <= t_cycle + 2'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External memory: page 0xC0 holds i^0x5A; other pages are distinguished by (page^0xC0).
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'hC0);
    endfunction

    assign bus_rdata = bus_enable ? mem_f(bus_addr) : 8'h00;
    assign hi_rdata  = hi_enable ? (hi_addr ^ 8'hA5) : 8'h00;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } oam_exp_t;

    oam_exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cyc = 0;
    int last_len = 0;
    int bus_wr_during_dma = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_range(input logic [7:0] page, input int lo, input int hi);
        oam_exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.addr = 8'(i);
            e.data = mem_f({page, 8'(i)});
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: pops one expectation per OAM write strobe.
    task automatic monitor();
        logic     prev_act = 1'b0;
        int       run = 0;
        oam_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && oam_write) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL oam_unexpected: write addr %0d data 0x%0h, none expected", oam_addr, oam_wdata);
                end else begin
                    e = sb.pop_front();
                    check("oam_addr", int'(oam_addr), int'(e.addr));
                    check("oam_wdata", int'(oam_wdata), int'(e.data));
                end
            end
            if (dma_active && bus_write) bus_wr_during_dma++;
            if (dma_active) begin
                if (!prev_act) begin
                    rise_cyc = cyc;
                    run = 0;
                end
                run++;
            end else if (prev_act) begin
                last_len = run;
            end
            prev_act = dma_active;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        while (t_cycle != 2'd0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d,
                          output logic bw, output logic [15:0] ba);
        align();
        cpu_addr = a; cpu_wdata = d; cpu_enable = 1'b1; cpu_write = 1'b1;
        @(negedge clk);
        bw = bus_write;
        ba = bus_addr;
        repeat (4) @(posedge clk);
        #1;
        cpu_enable = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d, output logic hien);
        align();
        cpu_addr = a; cpu_enable = 1'b1; cpu_write = 1'b0;
        @(negedge clk);
        d    = cpu_rdata;
        hien = hi_enable;
        repeat (4) @(posedge clk);
        #1;
        cpu_enable = 1'b0; cpu_addr = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (dma_active && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({"idle_timeout_", name}, int'(dma_active), 0);
        wait_clks(8);
        check({"sb_drained_", name}, sb.size(), 0);
    endtask

    logic [7:0]  rd;
    logic        hien;
    logic        bw;
    logic [15:0] ba;
    int          write_cyc;

    initial begin
        fork
            monitor();
        join_none

        reset = 1'b1;
        cpu_addr = 16'h0000; cpu_enable = 1'b0; cpu_write = 1'b0; cpu_wdata = 8'h00;
        wait_clks(3);
        check("rst_dma_active", int'(dma_active), 0);
        check("rst_oam_write", int'(oam_write), 0);
        check("rst_oam_addr", int'(oam_addr), 0);
        check("rst_oam_wdata", int'(oam_wdata), 0);
        check("rst_bus_enable", int'(bus_enable), 0);
        check("rst_hi_enable", int'(hi_enable), 0);
        reset = 1'b0;
        wait_clks(2);

        // Idle pass-through
        cpu_rd(16'h0150, rd, hien);
        check("idle_rd_0150", int'(rd), 'hCB);
        check("idle_rd_0150_hien", int'(hien), 0);
        cpu_rd(16'hFF46, rd, hien);
        check("rst_src", int'(rd), 'hFF);
        check("ff46_not_on_hi", int'(hien), 0);
        cpu_wr(16'hC100, 8'h77, bw, ba);
        check("idle_wr_bus_write", int'(bw), 1);
        check("idle_wr_bus_addr", int'(ba), 'hC100);

        // Basic transfer from 0xC000 with CPU traffic during DMA
        push_range(8'hC0, 0, 159);
        cpu_wr(16'hFF46, 8'hC0, bw, ba);
        write_cyc = cyc;
        wait_clks(8);
        cpu_rd(16'h0150, rd, hien);
        check("dma_rd_0150", int'(rd), 'hFF);
        cpu_wr(16'hC100, 8'h77, bw, ba);
        check("dma_wr_blocked", int'(bw), 0);
        cpu_rd(16'hFF80, rd, hien);
        check("dma_rd_ff80", int'(rd), 'h25);
        check("dma_rd_ff80_hien", int'(hien), 1);
        wait_idle("c0");
        check("c0_active_len", last_len, 640);
        check("c0_active_delay", rise_cyc - write_cyc, 4);
        check("bus_wr_during_dma", bus_wr_during_dma, 0);

        // Echo-RAM source 0xE1 maps to 0xC100
        push_range(8'hC1, 0, 159);
        cpu_wr(16'hFF46, 8'hE1, bw, ba);
        wait_clks(8);
        cpu_rd(16'hFF46, rd, hien);
        check("rd_src_e1", int'(rd), 'hE1);
        wait_idle("e1");
        check("e1_active_len", last_len, 640);

        // Restart at idx=50: one more byte from 0xC033, then 0xD000..0xD09F
        push_range(8'hC0, 0, 51);
        push_range(8'hD0, 0, 159);
        cpu_wr(16'hFF46, 8'hC0, bw, ba);
        wait_clks(4 + 4 * 50);
        cpu_wr(16'hFF46, 8'hD0, bw, ba);
        wait_idle("restart");
        check("restart_active_len", last_len, 848);

        // Asynchronous reset mid-M-cycle at idx=80
        push_range(8'hC0, 0, 79);
        cpu_wr(16'hFF46, 8'hC0, bw, ba);
        wait_clks(4 + 4 * 80);
        wait_clks(2);
        #3;
        reset = 1'b1;
        #1;
        check("arst_dma_active", int'(dma_active), 0);
        check("arst_oam_write", int'(oam_write), 0);
        check("arst_bus_enable", int'(bus_enable), 0);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(40);
        check("arst_sb_drained", sb.size(), 0);
        check("arst_stays_idle", int'(dma_active), 0);
        cpu_rd(16'hFF46, rd, hien);
        check("arst_src", int'(rd), 'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
